// File: rtl/axis_cmd_decoder.sv
// AXI-Stream command decoder: validates header destination/length and turns
// payload words into writes on a one-entry, back-pressurable register port.
module axis_cmd_decoder #(
  parameter logic [7:0] DEST_ID = 8'h01,
  parameter int         ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [31:0]       s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic [7:0]        s_axis_tdest,
  input  logic [3:0]        s_axis_tuser,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err_sop,
  output logic              err_len,
  output logic [15:0]       pkt_count,
  output logic [15:0]       drop_count
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         idx_q, idx_d;
  logic                wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                err_sop_q, err_sop_d;
  logic                err_len_q, err_len_d;
  logic [15:0]         pkt_q, pkt_d;
  logic [15:0]         drop_q, drop_d;

  logic                acc;
  logic                sop;
  logic                dest_ok;
  logic                last_word;
  logic [15:0]         hdr_len;
  logic                unused_tuser;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign unused_tuser = ^s_axis_tuser[3:1];
  assign sop       = s_axis_tuser[0];
  assign dest_ok   = (s_axis_tdest == DEST_ID) && (s_axis_tdata[31:24] == DEST_ID);
  assign hdr_len   = s_axis_tdata[15:0];
  assign last_word = ((idx_q + 16'd1) == len_q);
  assign acc       = s_axis_tvalid && s_axis_tready;

  // Only PAYLOAD back-pressures, and only on the write slot, never on tvalid.
  always_comb begin
    s_axis_tready = 1'b1;
    if (state_q == PAYLOAD) s_axis_tready = !wr_valid_q || wr_ready;
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    wr_valid_d = wr_valid_q && !wr_ready;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_sop_d  = 1'b0;
    err_len_d  = 1'b0;
    pkt_d      = pkt_q;
    drop_d     = drop_q;
    unique case (state_q)
      IDLE: if (acc) begin
        if (!sop) begin
          err_sop_d = 1'b1;
          state_d   = s_axis_tlast ? IDLE : DROP;
        end else if (!dest_ok) begin
          drop_d  = sat_inc(drop_q);
          state_d = s_axis_tlast ? IDLE : DROP;
        end else begin
          base_d = ADDR_W'(s_axis_tdata[23:16]);
          len_d  = hdr_len;
          idx_d  = 16'd0;
          if (s_axis_tlast) begin
            state_d = IDLE;
            if (hdr_len == 16'd0) pkt_d = sat_inc(pkt_q);
            else                  err_len_d = 1'b1;
          end else if (hdr_len == 16'd0) begin
            err_len_d = 1'b1;
            state_d   = DROP;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: if (acc) begin
        if (sop) begin
          err_sop_d = 1'b1;
          state_d   = s_axis_tlast ? IDLE : DROP;
        end else begin
          wr_valid_d = 1'b1;
          wr_addr_d  = base_q + ADDR_W'(idx_q);
          wr_data_d  = s_axis_tdata;
          idx_d      = idx_q + 16'd1;
          // Words already written are never rolled back on a short packet.
          if (s_axis_tlast) begin
            state_d = IDLE;
            if (last_word) pkt_d = sat_inc(pkt_q);
            else           err_len_d = 1'b1;
          end else if (last_word) begin
            err_len_d = 1'b1;
            state_d   = DROP;
          end
        end
      end
      DROP: if (acc && s_axis_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_sop_q  <= 1'b0;
      err_len_q  <= 1'b0;
      pkt_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_sop_q  <= err_sop_d;
      err_len_q  <= err_len_d;
      pkt_q      <= pkt_d;
      drop_q     <= drop_d;
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign err_sop    = err_sop_q;
  assign err_len    = err_len_q;
  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_axis_cmd_decoder.sv
// Bench for axis_cmd_decoder: packet-level reference model checked every cycle,
// plus literal expectations on the write log, counters and error pulse totals.
module tb_axis_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic [7:0]  s_axis_tdest;
  logic [3:0]  s_axis_tuser;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err_sop;
  logic        err_len;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;

  axis_cmd_decoder #(.DEST_ID(8'h01), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .err_sop(err_sop), .err_len(err_len),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: packet position plus the expected write slot.
  localparam int M_HDR = 0, M_BODY = 1, M_SKIP = 2;
  int          m_mode, m_base, m_len, m_cnt;
  logic        e_wv, e_sop, e_len;
  logic [7:0]  e_addr;
  logic [31:0] e_data;
  int          e_pkt, e_drop;
  int          log_addr[$];
  int          log_data[$];
  int          sop_seen = 0;
  int          len_seen = 0;

  always @(negedge clk) begin
    logic n_sop, n_len;
    if (!rst_n) begin
      m_mode = M_HDR; m_base = 0; m_len = 0; m_cnt = 0;
      e_wv = 1'b0; e_addr = 8'h00; e_data = 32'h0;
      e_sop = 1'b0; e_len = 1'b0; e_pkt = 0; e_drop = 0;
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_counts", {pkt_count, drop_count}, 0);
    end else begin
      chk("err_sop", err_sop, e_sop);
      chk("err_len", err_len, e_len);
      chk("pkt_count", pkt_count, e_pkt);
      chk("drop_count", drop_count, e_drop);
      chk("tready", s_axis_tready, (m_mode == M_BODY) ? (!e_wv || wr_ready) : 1'b1);
      chk("wr_valid", wr_valid, e_wv);
      if (e_wv) begin
        chk("wr_addr", wr_addr, e_addr);
        chk("wr_data", wr_data, e_data);
      end
      if (err_sop) sop_seen++;
      if (err_len) len_seen++;
      n_sop = 1'b0; n_len = 1'b0;
      if (wr_valid && wr_ready) begin
        log_addr.push_back(int'(wr_addr));
        log_data.push_back(int'(wr_data));
        e_wv = 1'b0;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        case (m_mode)
          M_HDR: begin
            if (!s_axis_tuser[0]) begin
              n_sop = 1'b1;
              m_mode = s_axis_tlast ? M_HDR : M_SKIP;
            end else if (s_axis_tdest != 8'h01 || s_axis_tdata[31:24] != 8'h01) begin
              if (e_drop < 65535) e_drop++;
              m_mode = s_axis_tlast ? M_HDR : M_SKIP;
            end else begin
              m_base = int'(s_axis_tdata[23:16]);
              m_len  = int'(s_axis_tdata[15:0]);
              m_cnt  = 0;
              if (s_axis_tlast) begin
                if (m_len == 0) begin if (e_pkt < 65535) e_pkt++; end
                else n_len = 1'b1;
                m_mode = M_HDR;
              end else if (m_len == 0) begin
                n_len = 1'b1; m_mode = M_SKIP;
              end else m_mode = M_BODY;
            end
          end
          M_BODY: begin
            if (s_axis_tuser[0]) begin
              n_sop = 1'b1;
              m_mode = s_axis_tlast ? M_HDR : M_SKIP;
            end else begin
              e_wv   = 1'b1;
              e_addr = 8'((m_base + m_cnt) % 256);
              e_data = s_axis_tdata;
              m_cnt++;
              if (s_axis_tlast) begin
                if (m_cnt == m_len) begin if (e_pkt < 65535) e_pkt++; end
                else n_len = 1'b1;
                m_mode = M_HDR;
              end else if (m_cnt == m_len) begin
                n_len = 1'b1; m_mode = M_SKIP;
              end
            end
          end
          default: if (s_axis_tlast) m_mode = M_HDR;
        endcase
      end
      e_sop = n_sop;
      e_len = n_len;
    end
  end

  // wr_ready patterns: 0 always high, 1 toggle, 2 low 5 cycles then high, 3 low.
  int rdy_mode = 0;
  initial begin
    int prev_mode = 0;
    int rcyc = 0;
    wr_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (rdy_mode != prev_mode) begin rcyc = 0; prev_mode = rdy_mode; end
      else rcyc++;
      case (rdy_mode)
        1:       wr_ready = ~wr_ready;
        2:       wr_ready = (rcyc >= 5);
        3:       wr_ready = 1'b0;
        default: wr_ready = 1'b1;
      endcase
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic last, input logic sop,
                           input logic [7:0] dest);
    int n = 0;
    bit done = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = last;
    s_axis_tuser = {3'b000, sop}; s_axis_tdest = dest;
    while (!done) begin
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) done = 1;
      @(posedge clk); #1;
      n++;
      if (!done && n > 50) begin
        n_cmp++; n_fail++;
        $display("FAIL send_timeout: beat %h not accepted within 50 cycles", d);
        done = 1;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input int i, input int a, input int d);
    if (i < log_addr.size()) begin
      chk($sformatf("log_addr[%0d]", i), log_addr[i], a);
      chk($sformatf("log_data[%0d]", i), log_data[i], d);
    end else chk("log_size_short", log_addr.size(), i + 1);
  endtask

  task automatic pkt_abc(input logic [7:0] base);
    send_beat({8'h01, base, 16'd3}, 1'b0, 1'b1, 8'h01);
    send_beat(32'hA, 1'b0, 1'b0, 8'h01);
    send_beat(32'hB, 1'b0, 1'b0, 8'h01);
    send_beat(32'hC, 1'b1, 1'b0, 8'h01);
  endtask

  initial begin
    rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    s_axis_tdest = '0; s_axis_tuser = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Basic packet, full throughput
    pkt_abc(8'h10);
    idle(3);
    chk("t1_log_size", log_addr.size(), 3);
    check_log(0, 'h10, 'hA); check_log(1, 'h11, 'hB); check_log(2, 'h12, 'hC);
    chk("t1_pkt", pkt_count, 1);

    // Back-pressure: toggling, then held low
    rdy_mode = 1; pkt_abc(8'h10); idle(4);
    rdy_mode = 2; pkt_abc(8'h10); idle(8);
    rdy_mode = 0; idle(1);
    chk("t2_log_size", log_addr.size(), 9);
    check_log(3, 'h10, 'hA); check_log(5, 'h12, 'hC);
    check_log(6, 'h10, 'hA); check_log(7, 'h11, 'hB); check_log(8, 'h12, 'hC);
    chk("t2_pkt", pkt_count, 3);

    // Foreign destination (TDEST, then header field), then a good packet
    send_beat({8'h01, 8'h30, 16'd2}, 1'b0, 1'b1, 8'h02);
    send_beat(32'h11, 1'b0, 1'b0, 8'h02);
    send_beat(32'h12, 1'b1, 1'b0, 8'h02);
    send_beat({8'h03, 8'h30, 16'd0}, 1'b1, 1'b1, 8'h01);
    send_beat({8'h01, 8'h40, 16'd1}, 1'b0, 1'b1, 8'h01);
    send_beat(32'h55, 1'b1, 1'b0, 8'h01);
    idle(3);
    chk("t3_drop", drop_count, 2);
    chk("t3_pkt", pkt_count, 4);
    check_log(9, 'h40, 'h55);

    // Length errors: short packet, then long packet
    send_beat({8'h01, 8'h50, 16'd4}, 1'b0, 1'b1, 8'h01);
    send_beat(32'h21, 1'b0, 1'b0, 8'h01);
    send_beat(32'h22, 1'b1, 1'b0, 8'h01);
    send_beat({8'h01, 8'h60, 16'd1}, 1'b0, 1'b1, 8'h01);
    send_beat(32'h31, 1'b0, 1'b0, 8'h01);
    send_beat(32'h32, 1'b0, 1'b0, 8'h01);
    send_beat(32'h33, 1'b1, 1'b0, 8'h01);
    idle(3);
    chk("t4_len_pulses", len_seen, 2);
    chk("t4_log_size", log_addr.size(), 13);
    check_log(10, 'h50, 'h21); check_log(11, 'h51, 'h22); check_log(12, 'h60, 'h31);

    // SOP errors: missing on first beat, then repeated mid-packet
    send_beat({8'h01, 8'h00, 16'd1}, 1'b0, 1'b0, 8'h01);
    send_beat(32'h99, 1'b1, 1'b0, 8'h01);
    send_beat({8'h01, 8'h70, 16'd3}, 1'b0, 1'b1, 8'h01);
    send_beat(32'h41, 1'b0, 1'b0, 8'h01);
    send_beat(32'h42, 1'b0, 1'b1, 8'h01);
    send_beat(32'h43, 1'b1, 1'b0, 8'h01);
    idle(3);
    chk("t5_sop_pulses", sop_seen, 2);
    chk("t5_log_size", log_addr.size(), 14);
    check_log(13, 'h70, 'h41);

    // Address wrap
    send_beat({8'h01, 8'hFE, 16'd3}, 1'b0, 1'b1, 8'h01);
    send_beat(32'hE0, 1'b0, 1'b0, 8'h01);
    send_beat(32'hE1, 1'b0, 1'b0, 8'h01);
    send_beat(32'hE2, 1'b1, 1'b0, 8'h01);
    idle(3);
    check_log(14, 'hFE, 'hE0); check_log(15, 'hFF, 'hE1); check_log(16, 'h00, 'hE2);
    chk("t6_pkt", pkt_count, 5);

    // Reset mid-payload with a write pending
    send_beat({8'h01, 8'h20, 16'd4}, 1'b0, 1'b1, 8'h01);
    send_beat(32'h71, 1'b0, 1'b0, 8'h01);
    rdy_mode = 3;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_now_wr_valid", wr_valid, 0);
    chk("rst_now_wr_addr", wr_addr, 0);
    chk("rst_now_wr_data", wr_data, 0);
    chk("rst_now_errs", {err_sop, err_len}, 0);
    chk("rst_now_pkt", pkt_count, 0);
    chk("rst_now_drop", drop_count, 0);
    chk("rst_now_tready", s_axis_tready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_mode = 0;
    send_beat(32'h72, 1'b0, 1'b0, 8'h01);
    send_beat(32'h73, 1'b0, 1'b0, 8'h01);
    send_beat(32'h74, 1'b1, 1'b0, 8'h01);
    send_beat({8'h01, 8'h80, 16'd2}, 1'b0, 1'b1, 8'h01);
    send_beat(32'h81, 1'b0, 1'b0, 8'h01);
    send_beat(32'h82, 1'b1, 1'b0, 8'h01);
    idle(3);
    chk("t7_sop_pulses", sop_seen, 3);
    chk("t7_pkt", pkt_count, 1);
    chk("t7_log_size", log_addr.size(), 19);
    check_log(17, 'h80, 'h81); check_log(18, 'h81, 'h82);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_cmd_decoder.md
# axis_cmd_decoder

Downstream consumer of the host-to-FPGA AXI-Stream command channel. Receives packets whose first beat is a header (TUSER[0]=1) and whose remaining beats are payload. Validates destination and length, then converts each payload word into a register write on a one-entry, back-pressurable write port toward the register file. Malformed or foreign packets are discarded up to TLAST, flagged, and counted.

## Interface
- DEST_ID, 8'h01, TDEST/header destination this decoder accepts
- ADDR_W, 8, register address width; addresses wrap modulo 2^ADDR_W
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_axis_tvalid  in  1  stream beat valid
- s_axis_tready  out  1  stream beat accepted when tvalid&&tready
- s_axis_tdata  in  32  header: [31:24] dest, [23:16] base address, [15:0] payload length N in words; otherwise payload word
- s_axis_tlast  in  1  last beat of packet
- s_axis_tdest  in  8  routing destination, must equal DEST_ID on header
- s_axis_tuser  in  4  [0]=start of packet; [3:1] ignored
- wr_valid  out  1  register write pending
- wr_ready  in  1  register file accepts write when wr_valid&&wr_ready
- wr_addr  out  ADDR_W  write address
- wr_data  out  32  write data
- err_sop  out  1  one-cycle pulse: SOP missing on first beat or SOP seen mid-packet
- err_len  out  1  one-cycle pulse: TLAST position disagrees with header length
- pkt_count  out  16  packets completed without error, saturating at 16'hFFFF
- drop_count  out  16  packets rejected for destination mismatch, saturating

## Operation
- States: IDLE (expect header), PAYLOAD, DROP (discard to TLAST).
- IDLE: s_axis_tready=1. On accepted beat:
  - tuser[0]=0: err_sop; stay IDLE if tlast, else DROP.
  - tuser[0]=1 and (tdest!=DEST_ID or tdata[31:24]!=DEST_ID): drop_count++; DROP unless tlast.
  - tuser[0]=1, destination ok: latch base=tdata[23:16] (truncated/zero-extended to ADDR_W), len=tdata[15:0], idx=0.
    - tlast and len==0: pkt_count++, stay IDLE.
    - tlast and len!=0: err_len, stay IDLE.
    - !tlast and len==0: err_len, DROP.
    - !tlast and len!=0: PAYLOAD.
- PAYLOAD: s_axis_tready = !wr_valid || wr_ready. On accepted beat:
  - tuser[0]=1: err_sop; beat not written; IDLE if tlast else DROP.
  - otherwise load write slot: wr_addr=base+idx (mod 2^ADDR_W), wr_data=tdata, wr_valid=1; idx++.
    - tlast and idx+1==len: pkt_count++, IDLE.
    - tlast and idx+1<len: err_len, IDLE (words already written stay written; no rollback).
    - !tlast and idx+1==len: err_len, DROP (excess beats discarded).
- DROP: s_axis_tready=1; discard beats; accepted beat with tlast -> IDLE. No flags raised in DROP.
- Write slot: wr_valid clears on wr_ready unless reloaded same cycle; wr_addr/wr_data stable while wr_valid && !wr_ready.
- At most one err_* pulse per accepted beat; err_sop and err_len never assert together.
- Counters saturate; never wrap.

## Timing
- Reset (async assert, sync release): state IDLE, s_axis_tready=1 after release, wr_valid=0, wr_addr=0, wr_data=0, err_sop=0, err_len=0, pkt_count=0, drop_count=0, idx/base/len=0.
- Reset mid-packet: pending write lost; following non-SOP beats hit IDLE -> err_sop, DROP to TLAST.
- Accepted payload beat appears on wr_* the next cycle.
- Sustained throughput 1 word/cycle with wr_ready=1; header beat costs one cycle with no write.
- s_axis_tready in PAYLOAD is combinational from wr_valid and wr_ready only (no dependency on tvalid).
- err_* pulse and counter increment occur the cycle after the triggering beat is accepted.

## Test plan
- Header {8'h01,8'h10,16'd3}, TDEST=1, SOP, then 32'hA, 32'hB, 32'hC (last), wr_ready=1 -> writes (0x10,A),(0x11,B),(0x12,C) on consecutive cycles; pkt_count=1, no errors.
- Same packet, wr_ready toggling 1010... and held low 5 cycles -> tready drops while slot full; no write lost or duplicated; wr_addr/wr_data stable while stalled.
- Header TDEST=8'h02, 2 payload beats -> no writes, drop_count=1, tready=1 throughout, next valid packet processed normally.
- Length errors: header len=4 with TLAST on 2nd payload -> 2 writes then err_len, IDLE; header len=1 with 3 payload beats -> 1 write, err_len, beats 2-3 discarded.
- SOP errors: first beat without tuser[0] -> err_sop, drop to TLAST; SOP asserted on 2nd payload beat -> err_sop, that beat not written.
- Base 8'hFE, len=3 -> addresses 0xFE,0xFF,0x00; assert rst_n low mid-payload -> all outputs reset immediately, pending write dropped, remainder of packet yields err_sop and is discarded.
